// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: zero-fills x1..x31 after reset, then round-robin arbitrates the register file write port
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   req_valid/req_ready       per-requester handshake; ready is a one-hot grant
//   req_rd/req_wdata          packed per-requester destination register and data
//   rf_en/rf_we/rf_rd/rf_wdata registered register file write port
//   wb_pend/wb_pend_rd        write in flight this cycle, for the hazard unit
//   init_done                 zero-fill finished, requests being accepted
module regfile_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREQ = 3,
  parameter int INIT_ZERO = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*5-1:0]    req_rd,
  input  logic [NREQ*XLEN-1:0] req_wdata,
  output logic                 rf_en,
  output logic                 rf_we,
  output logic [4:0]           rf_rd,
  output logic [XLEN-1:0]      rf_wdata,
  output logic                 wb_pend,
  output logic [4:0]           wb_pend_rd,
  output logic                 init_done
);
  localparam int PW = $clog2(NREQ);
  typedef enum logic {INIT, RUN} state_t;
  state_t state;
  logic [4:0] idx;
  logic [PW-1:0] ptr, sel;
  logic found;
  always_comb begin
    sel = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++)
      if (!found && req_valid[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        sel = PW'((int'(ptr) + k) % NREQ);
      end
    req_ready = (state == RUN && found) ? NREQ'(1) << sel : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT_ZERO != 0 ? INIT : RUN;
      idx <= 5'd1;
      ptr <= '0;
      rf_we <= 1'b0;
      rf_rd <= '0;
      rf_wdata <= '0;
      init_done <= INIT_ZERO == 0;
    end else if (state == INIT) begin
      rf_we <= 1'b1;
      rf_rd <= idx;
      rf_wdata <= '0;
      idx <= idx + 5'd1;
      if (idx == 5'd31) begin
        state <= RUN;
        init_done <= 1'b1;
      end
    end else if (found) begin
      // x0 writes complete the handshake but never reach the array
      rf_rd <= req_rd[int'(sel)*5 +: 5];
      rf_wdata <= req_wdata[int'(sel)*XLEN +: XLEN];
      rf_we <= req_rd[int'(sel)*5 +: 5] != 5'd0;
      ptr <= (sel == PW'(NREQ - 1)) ? '0 : sel + 1'b1;
    end else begin
      rf_we <= 1'b0;
    end
  end
  assign rf_en = rf_we;
  assign wb_pend = rf_we;
  assign wb_pend_rd = rf_rd;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: scoreboard bench with a reference model of zero-fill and round-robin write arbitration
module tb_regfile_wb_arbiter;
  localparam int N = 3;
  localparam int X = 32;
  typedef struct {
    int c;
    logic [4:0] rd;
    logic [X-1:0] d;
  } wr_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [N-1:0] valid, ready0, v1, ready1, hs, exp_rdy;
  logic [N*5-1:0] rd, rd1;
  logic [N*X-1:0] wd, wd1;
  logic en0, we0, pend0, done0, en1, we1, pend1, done1;
  logic [4:0] rfrd0, pendrd0, rfrd1, pendrd1;
  logic [X-1:0] rfwd0, rfwd1;
  regfile_wb_arbiter #(.XLEN(X), .NREQ(N), .INIT_ZERO(1)) u0 (
    .clk(clk), .rst(rst), .req_valid(valid), .req_ready(ready0), .req_rd(rd), .req_wdata(wd),
    .rf_en(en0), .rf_we(we0), .rf_rd(rfrd0), .rf_wdata(rfwd0), .wb_pend(pend0),
    .wb_pend_rd(pendrd0), .init_done(done0));
  regfile_wb_arbiter #(.XLEN(X), .NREQ(N), .INIT_ZERO(0)) u1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(ready1), .req_rd(rd1), .req_wdata(wd1),
    .rf_en(en1), .rf_we(we1), .rf_rd(rfrd1), .rf_wdata(rfwd1), .wb_pend(pend1),
    .wb_pend_rd(pendrd1), .init_done(done1));
  wr_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int t1 = -10;
  int g;
  bit armed = 0;
  bit end_req = 0;
  bit end_done = 0;
  bit m_init = 1;
  bit m_done = 0;
  int m_idx = 1;
  int m_ptr = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) armed <= 1;
  end
  // Reference model: decides the grant from the rules and queues the write each grant must produce
  always @(negedge clk) if (armed) begin
    exp_rdy = '0;
    g = -1;
    if (!m_init)
      for (int k = 0; k < N; k++)
        if (g < 0 && valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    if (g >= 0) exp_rdy[g] = 1'b1;
    n_chk++;
    if (ready0 !== exp_rdy) begin
      n_fail++;
      $display("FAIL ready cyc=%0d got %b expected %b", cyc, ready0, exp_rdy);
    end
    n_chk++;
    if (done0 !== m_done) begin
      n_fail++;
      $display("FAIL init_done cyc=%0d got %b expected %b", cyc, done0, m_done);
    end
    if (rst) begin
      m_init = 1;
      m_idx = 1;
      m_ptr = 0;
      m_done = 0;
    end else if (m_init) begin
      q.push_back('{cyc + 1, 5'(m_idx), '0});
      if (m_idx == 31) begin
        m_init = 0;
        m_done = 1;
      end
      m_idx++;
    end else if (g >= 0) begin
      if (rd[g*5 +: 5] != 5'd0) q.push_back('{cyc + 1, rd[g*5 +: 5], wd[g*X +: X]});
      m_ptr = (g + 1) % N;
    end
  end
  // Monitor: whatever appears on the write port must match the queue head due this cycle
  always @(negedge clk) if (armed) begin
    if (q.size() > 0 && q[0].c < cyc) begin
      n_chk++;
      n_fail++;
      $display("FAIL stale cyc=%0d expected write rd=%0d at cyc %0d never seen", cyc, q[0].rd, q[0].c);
      void'(q.pop_front());
    end
    n_chk++;
    if (q.size() > 0 && q[0].c == cyc) begin
      if (we0 !== 1'b1 || rfrd0 !== q[0].rd || rfwd0 !== q[0].d) begin
        n_fail++;
        $display("FAIL write cyc=%0d got we=%b rd=%0d data=%h expected we=1 rd=%0d data=%h",
                 cyc, we0, rfrd0, rfwd0, q[0].rd, q[0].d);
      end
      void'(q.pop_front());
    end else if (we0 !== 1'b0) begin
      n_fail++;
      $display("FAIL idle cyc=%0d got we=%b rd=%0d expected we=0", cyc, we0, rfrd0);
    end
    n_chk++;
    if (en0 !== we0 || pend0 !== we0 || pendrd0 !== rfrd0) begin
      n_fail++;
      $display("FAIL alias cyc=%0d got en=%b pend=%b pend_rd=%0d expected we=%b rd=%0d",
               cyc, en0, pend0, pendrd0, we0, rfrd0);
    end
    if (end_req && !end_done) begin
      end_done = 1;
      n_chk++;
      if (q.size() != 0) begin
        n_fail++;
        $display("FAIL drain got %0d outstanding writes expected 0", q.size());
      end
    end
  end
  // Instance without zero-fill: must grant in the first cycle out of reset
  always @(negedge clk) begin
    if (cyc == t1) begin
      n_chk++;
      if (done1 !== 1'b1 || ready1 !== 3'b010) begin
        n_fail++;
        $display("FAIL nofill_grant got done=%b ready=%b expected done=1 ready=010", done1, ready1);
      end
    end
    if (cyc == t1 + 1) begin
      n_chk++;
      if (we1 !== 1'b1 || rfrd1 !== 5'd3 || rfwd1 !== 32'hAA) begin
        n_fail++;
        $display("FAIL nofill_write got we=%b rd=%0d data=%h expected we=1 rd=3 data=000000aa",
                 we1, rfrd1, rfwd1);
      end
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    valid = '0;
    rd = {5'd7, 5'd6, 5'd5};
    wd = {32'h7777, 32'h6666, 32'h5555};
    v1 = '0;
    rd1 = '0;
    wd1 = '0;
    step(2);
    rst = 0;
    v1 = 3'b010;
    rd1[5 +: 5] = 5'd3;
    wd1[X +: X] = 32'hAA;
    t1 = cyc;
    valid = 3'b111;
    step(1);
    v1 = '0;
    step(10);
    rst = 1;
    step(1);
    rst = 0;
    step(31 + 9);
    valid = 3'b100;
    rd[10 +: 5] = 5'd9;
    wd[64 +: 32] = 32'hDEADBEEF;
    step(1);
    valid = 3'b101;
    step(2);
    valid = 3'b010;
    rd[5 +: 5] = 5'd0;
    wd[32 +: 32] = 32'h1234;
    step(1);
    valid = 3'b111;
    rd[5 +: 5] = 5'd6;
    step(1);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      hs = ready0 & valid;
      step(1);
      rst = (n == 200);
      for (int i = 0; i < N; i++)
        if (!valid[i] || hs[i]) begin
          valid[i] = $urandom_range(0, 3) != 0;
          rd[i*5 +: 5] = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 8));
          wd[i*X +: X] = $urandom;
        end
    end
    rst = 0;
    valid = '0;
    step(3);
    end_req = 1;
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
